wave_capture: RTL and testbench
===============================

Name: wave_capture

Overview:
- Upstream producer for the waveform display stage.
- Watches the signed 16-bit audio sample stream and arms on a positive-going zero crossing.
- Writes 256 consecutive samples as 8-bit offset-binary values into the inactive half of a 512-entry double-buffered sample RAM.
- Swaps buffers by toggling read_index, but only once the display reports it is idle, so the display never reads a partially written buffer.

Parameters:
- NUM_SAMPLES, 256: samples per capture. Power of two, 2..256. Write address low field is 8 bits.
- ARM_TIMEOUT, 4096: samples spent in ARMED without a crossing before a forced trigger. 0 disables forced triggering.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid in that cycle.
- new_sample_in  input  16  signed two's-complement audio sample.
- wave_display_idle  input  1  high while the display is not scanning the wave region (vertical blank).
- write_enable  output  1  RAM write strobe, one cycle per captured sample.
- write_address  output  9  {bank, index[7:0]}.
- write_sample  output  8  offset-binary sample.
- read_index  output  1  bank the display reads; this block writes bank ~read_index.

Behaviour:
- Reset (async assert, sync release):
  - state = ARMED
  - read_index = 0
  - write_enable = 0, write_address = 0, write_sample = 0
  - index counter = 0, arm counter = 0, prev_neg = 0
- Sample conversion: write_sample = {~s[15], s[14:8]}.
  - 0x8000 -> 0x00
  - 0x0000 -> 0x80
  - 0x7FFF -> 0xFF
- prev_neg:
  - Loaded with new_sample_in[15] on every new_sample_ready, in all states.
  - Holds its value when no strobe is present.
- Write port:
  - All three write outputs are registered.
  - write_enable is high exactly in the cycle after an accepted sample, otherwise 0.
  - write_address = {~read_index, idx}.
  - write_address and write_sample hold their last values while write_enable = 0.
- ARMED:
  - On new_sample_ready with prev_neg = 1 and new_sample_in[15] = 0, or on a forced trigger:
    - write the sample at idx 0
    - idx <= 1
    - go to ACTIVE (or straight to WAIT when NUM_SAMPLES = 1 is disallowed, so never)
  - Otherwise increment the arm counter by 1 per strobe.
  - Forced trigger: fires on the strobe where arm counter = ARM_TIMEOUT-1, when ARM_TIMEOUT != 0. That sample is written at idx 0 regardless of sign.
  - Arm counter clears on entry to ARMED and on trigger.
- ACTIVE:
  - Each new_sample_ready writes at the current idx, then idx increments.
  - No trigger check in this state.
  - After writing idx = NUM_SAMPLES-1: go to WAIT, idx <= 0.
- WAIT:
  - Samples are not written; only prev_neg updates.
  - In the first cycle with wave_display_idle = 1: toggle read_index, go to ARMED.
  - The first trigger check after the swap uses the next strobe.
- Simultaneous events and gaps:
  - wave_display_idle is ignored outside WAIT.
  - A new_sample_ready arriving in the same cycle as the WAIT->ARMED transition is treated under WAIT rules (not written).
  - Back-to-back strobes on consecutive cycles must each be captured.
- Bank safety: the written bank is always ~read_index, and read_index changes only in WAIT, after the final write has completed.
- Reset mid-capture: the partial capture is abandoned and read_index returns to 0. RAM contents are not cleared.
- States encoded in 2 bits; the unused code recovers to ARMED on the next clock.

Test Plan:
- Reset: assert reset_n = 0 mid-ACTIVE -> all outputs 0 immediately, read_index = 0. After release, no write until a crossing occurs.
- Crossing trigger: samples 0xFF00, 0xFFF0, 0x0010 (strobe every 4 cycles):
  - First write is address 0x100, data 0x80, one cycle after the 0x0010 strobe.
  - No writes for the negative samples.
- Full capture: after trigger, feed 255 more samples of value 0x4000 -> writes at addresses 0x101..0x1FF with data 0xC0, then write_enable stays 0 on further strobes. With wave_display_idle = 1 -> read_index becomes 1 on the following cycle.
- WAIT hold: keep wave_display_idle = 0 for 1000 strobes -> no writes, read_index unchanged. Raise idle -> exactly one toggle. The next capture writes to 0x000..0x0FF.
- Forced trigger: ARM_TIMEOUT = 8, constant 0x1234 input -> 8th strobe after arming is written at idx 0 with data 0x92. With ARM_TIMEOUT = 0, the same stimulus produces no writes.
- Back-to-back strobes: new_sample_ready high for 256 consecutive cycles after a crossing -> 256 consecutive write_enable pulses, with addresses incrementing by 1 each cycle.

Source files
------------

// File: rtl/wave_capture.sv
// wave_capture: arms on a positive-going zero crossing of the audio stream and
// writes one capture of offset-binary samples into the bank the display is not
// reading. Banks swap only while the display is idle, so the display never
// scans a buffer that is still being filled.
module wave_capture #(
  parameter int unsigned NUM_SAMPLES = 256,
  parameter int unsigned ARM_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        new_sample_ready,
  input  logic [15:0] new_sample_in,
  input  logic        wave_display_idle,
  output logic        write_enable,
  output logic [8:0]  write_address,
  output logic [7:0]  write_sample,
  output logic        read_index
);

  // Arm counter only needs to reach ARM_TIMEOUT-1; with forcing disabled it wraps harmlessly.
  localparam int unsigned AW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TIMEOUT - 1);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_idx;
  logic [AW-1:0] r_arm_cnt;
  logic          r_prev_neg;

  logic          w_crossing;
  logic          w_forced;
  logic [7:0]    w_offset;

  assign w_crossing = r_prev_neg & ~new_sample_in[15];
  assign w_forced   = (ARM_TIMEOUT != 0) && (r_arm_cnt == ARM_LAST);
  assign w_offset   = {~new_sample_in[15], new_sample_in[14:8]};

  // Capture FSM with registered RAM write port and bank select.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_ARMED;
      r_idx         <= '0;
      r_arm_cnt     <= '0;
      r_prev_neg    <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      write_enable <= 1'b0;
      if (new_sample_ready) begin
        r_prev_neg <= new_sample_in[15];
      end

      case (r_state)
        ST_ARMED: begin
          if (new_sample_ready) begin
            if (w_crossing || w_forced) begin
              write_enable  <= 1'b1;
              write_address <= {~read_index, 8'd0};
              write_sample  <= w_offset;
              r_idx         <= 8'd1;
              r_arm_cnt     <= '0;
              r_state       <= ST_ACTIVE;
            end else begin
              r_arm_cnt <= r_arm_cnt + AW'(1);
            end
          end
        end

        ST_ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, r_idx};
            write_sample  <= w_offset;
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= ST_WAIT;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end

        ST_WAIT: begin
          // A strobe in the swap cycle is deliberately dropped; only prev_neg sees it.
          if (wave_display_idle) begin
            read_index <= ~read_index;
            r_arm_cnt  <= '0;
            r_state    <= ST_ARMED;
          end
        end

        default: begin
          r_idx     <= '0;
          r_arm_cnt <= '0;
          r_state   <= ST_ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: three instances (default timeout, timeout 8, timeout
// disabled) share one randomized input stream and are compared every cycle
// against a transaction-level capture model, plus directed scenario checks.
module tb_wave_capture;

  logic        clk;
  logic        reset_n;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;

  logic [2:0]  w_we;
  logic [2:0]  w_ridx;
  logic [8:0]  w_addr [3];
  logic [7:0]  w_data [3];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt [3] = '{0, 0, 0};

  wave_capture u_dut (
    .clk(clk), .reset_n(reset_n), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
    .write_enable(w_we[0]), .write_address(w_addr[0]), .write_sample(w_data[0]),
    .read_index(w_ridx[0])
  );

  wave_capture #(.ARM_TIMEOUT(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
    .write_enable(w_we[1]), .write_address(w_addr[1]), .write_sample(w_data[1]),
    .read_index(w_ridx[1])
  );

  wave_capture #(.ARM_TIMEOUT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
    .write_enable(w_we[2]), .write_address(w_addr[2]), .write_sample(w_data[2]),
    .read_index(w_ridx[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (capture transactions) ----------------
  int unsigned m_timeout [3] = '{4096, 8, 0};
  int          m_mode    [3];   // 0 hunting, 1 filling, 2 waiting for display
  int unsigned m_since   [3];   // strobes seen since arming
  int unsigned m_count   [3];   // samples stored in current capture
  logic        m_prev    [3];
  logic        m_bank    [3];   // bank the display reads
  logic [2:0]  e_we;
  logic [8:0]  e_addr    [3];
  logic [7:0]  e_data    [3];

  function automatic logic [7:0] to_offset(input logic [15:0] s);
    int v;
    v = $signed(s) >>> 8;
    return 8'(v + 128);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_since[i] = 0; m_count[i] = 0;
      m_prev[i] = 1'b0; m_bank[i] = 1'b0;
      e_we[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
    end
  endtask

  task automatic model_emit(input int i);
    e_we[i]   = 1'b1;
    e_addr[i] = 9'((m_bank[i] ? 0 : 256) + m_count[i]);
    e_data[i] = to_offset(new_sample_in);
    m_count[i]++;
  endtask

  task automatic model_step(input int i);
    e_we[i] = 1'b0;
    if (m_mode[i] == 0) begin
      if (new_sample_ready) begin
        if ((m_prev[i] && !new_sample_in[15]) ||
            (m_timeout[i] != 0 && m_since[i] + 1 == m_timeout[i])) begin
          m_count[i] = 0;
          model_emit(i);
          m_mode[i]  = 1;
          m_since[i] = 0;
        end else begin
          m_since[i]++;
        end
      end
    end else if (m_mode[i] == 1) begin
      if (new_sample_ready) begin
        model_emit(i);
        if (m_count[i] == 256) m_mode[i] = 2;
      end
    end else if (wave_display_idle) begin
      m_bank[i]  = !m_bank[i];
      m_mode[i]  = 0;
      m_since[i] = 0;
    end
    if (new_sample_ready) m_prev[i] = new_sample_in[15];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("we%0d", i),   w_we[i],   e_we[i]);
        check($sformatf("addr%0d", i), w_addr[i], e_addr[i]);
        check($sformatf("data%0d", i), w_data[i], e_data[i]);
        check($sformatf("ridx%0d", i), w_ridx[i], m_bank[i]);
        if (w_we[i] === 1'b1) wr_cnt[i]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    new_sample_ready = 1'b1;
    new_sample_in    = v;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  initial begin
    int base;
    logic [15:0] v;
    reset_n = 1'b0;
    new_sample_ready = 1'b0;
    new_sample_in = '0;
    wave_display_idle = 1'b0;
    cycles(3);
    check("rst_we", w_we[0], 0);
    check("rst_addr", w_addr[0], 0);
    check("rst_data", w_data[0], 0);
    check("rst_ridx", w_ridx[0], 0);
    reset_n = 1'b1;
    cycles(2);

    // Crossing trigger
    strobe(16'hFF00); check("neg1_we", w_we[0], 0); cycles(3);
    strobe(16'hFFF0); check("neg2_we", w_we[0], 0); cycles(3);
    strobe(16'h0010);
    check("trig_we", w_we[0], 1);
    check("trig_addr", w_addr[0], 9'h100);
    check("trig_data", w_data[0], 8'h80);

    // Remainder of the capture
    for (int k = 1; k < 256; k++) begin
      cycles(1);
      strobe(16'h4000);
      check("fill_we", w_we[0], 1);
      check("fill_addr", w_addr[0], 9'h100 + k);
      check("fill_data", w_data[0], 8'hC0);
    end
    for (int k = 0; k < 4; k++) begin
      cycles(1);
      strobe(16'($urandom));
      check("post_we", w_we[0], 0);
    end
    check("post_ridx", w_ridx[0], 0);

    // Display busy for a long time
    base = wr_cnt[0];
    repeat (1000) strobe(16'($urandom));
    cycles(1);
    check("hold_writes", wr_cnt[0] - base, 0);
    check("hold_ridx", w_ridx[0], 0);
    wave_display_idle = 1'b1;
    cycles(1);
    check("swap_ridx", w_ridx[0], 1);
    cycles(4);
    check("swap_once", w_ridx[0], 1);
    wave_display_idle = 1'b0;

    // Back-to-back capture into bank 0
    strobe(16'h8000);
    base = wr_cnt[0];
    for (int k = 0; k < 256; k++) begin
      v = (k == 0) ? 16'($urandom_range(0, 16'h7FFF)) : 16'($urandom);
      new_sample_ready = 1'b1;
      new_sample_in = v;
      @(posedge clk);
      #1;
      check("b2b_we", w_we[0], 1);
      check("b2b_addr", w_addr[0], k);
      check("b2b_data", w_data[0], to_offset(v));
    end
    new_sample_ready = 1'b0;
    cycles(1);
    check("b2b_end_we", w_we[0], 0);
    check("b2b_count", wr_cnt[0] - base, 256);

    // Swap back, fill bank 1 with gapped strobes, swap again
    wave_display_idle = 1'b1; cycles(1); wave_display_idle = 1'b0;
    check("swap2_ridx", w_ridx[0], 0);
    strobe(16'h8000); strobe(16'h0100);
    repeat (255) begin
      strobe(16'($urandom));
      cycles($urandom_range(0, 2));
    end
    wave_display_idle = 1'b1; cycles(1); wave_display_idle = 1'b0;
    check("swap3_ridx", w_ridx[0], 1);

    // Reset in the middle of a capture
    strobe(16'h8000); strobe(16'h0200);
    repeat (20) strobe(16'($urandom));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_we", w_we[0], 0);
    check("mid_rst_addr", w_addr[0], 0);
    check("mid_rst_data", w_data[0], 0);
    check("mid_rst_ridx", w_ridx[0], 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Forced trigger (timeout 8) vs. disabled (timeout 0)
    base = wr_cnt[2];
    for (int i = 0; i < 10; i++) begin
      strobe(16'h1234);
      check("forced_we", w_we[1], i >= 7);
      if (i == 7) begin
        check("forced_addr", w_addr[1], 9'h100);
        check("forced_data", w_data[1], 8'h92);
      end
      check("notimeout_we", w_we[2], 0);
      check("default_we", w_we[0], 0);
    end
    cycles(1);
    check("notimeout_count", wr_cnt[2] - base, 0);

    // Randomized traffic with occasional asynchronous reset
    repeat (4000) begin
      new_sample_ready  = ($urandom_range(0, 3) != 0);
      new_sample_in     = 16'($urandom);
      wave_display_idle = ($urandom_range(0, 15) == 0);
      reset_n           = ($urandom_range(0, 999) != 0);
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    new_sample_ready = 1'b0;
    wave_display_idle = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
